// File: rtl/riscv_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_mem_pkg
// Purpose  : Shared types and constants for the data-port memory responder.
//            Holds the access-width encoding, the responder state encoding
//            and the number of byte lanes per memory word.
// Contents : BYTES_PER_WORD, mem_width_e, mem_rsp_state_e
// Revision : 1.0 - initial release
// ============================================================================
package riscv_mem_pkg;

    localparam int BYTES_PER_WORD = 4;

    // Encoding matches the raw req_width bus so a plain cast is enough.
    typedef enum logic [1:0] {
        MW_BYTE = 2'b00,
        MW_HALF = 2'b01,
        MW_WORD = 2'b10,
        MW_RSVD = 2'b11
    } mem_width_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } mem_rsp_state_e;

endpackage
`default_nettype wire

// File: rtl/mem_lane_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_lane_ctrl
// Purpose  : Combinational byte-lane steering for one 32-bit memory word.
//            Selects the starting lane from the low address bits and the
//            access width, produces the byte-enable mask, moves lane-0
//            aligned store data up to that lane, and pulls the selected
//            bytes of a read word down to bit 0 with zero fill.
// Ports    : addr_lo_i  - byte address bits [1:0]
//            width_i    - access width (byte/half/word/reserved)
//            wdata_i    - store data, lane-0 aligned
//            rword_i    - full memory word being read
//            be_o       - byte enables (all zero for reserved width)
//            wdata_o    - store data shifted into the selected lanes
//            rdata_o    - selected bytes moved to bit 0, upper bits zero
// Revision : 1.0 - initial release
// ============================================================================
module mem_lane_ctrl
    import riscv_mem_pkg::*;
(
    input  logic [1:0]                addr_lo_i,
    input  mem_width_e                width_i,
    input  logic [31:0]               wdata_i,
    input  logic [31:0]               rword_i,
    output logic [BYTES_PER_WORD-1:0] be_o,
    output logic [31:0]               wdata_o,
    output logic [31:0]               rdata_o
);

    logic [1:0]  lane;
    logic [4:0]  shamt;
    logic [31:0] rshift;

    always_comb begin
        lane    = 2'b00;
        be_o    = '0;
        rdata_o = '0;

        // A half access ignores addr[0]: it always starts on an even lane.
        case (width_i)
            MW_BYTE: begin
                lane = addr_lo_i;
                be_o = 4'b0001 << addr_lo_i;
            end
            MW_HALF: begin
                lane = {addr_lo_i[1], 1'b0};
                be_o = 4'b0011 << lane;
            end
            MW_WORD: begin
                lane = 2'b00;
                be_o = 4'b1111;
            end
            default: begin
                lane = 2'b00;
                be_o = 4'b0000;
            end
        endcase

        shamt   = {lane, 3'b000};
        wdata_o = wdata_i << shamt;
        rshift  = rword_i >> shamt;

        case (width_i)
            MW_BYTE: rdata_o = {24'h000000, rshift[7:0]};
            MW_HALF: rdata_o = {16'h0000, rshift[15:0]};
            MW_WORD: rdata_o = rshift;
            default: rdata_o = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Purpose  : Handshaked data-memory responder with programmable wait states.
//            Accepts one load/store at a time, waits LATENCY cycles, then
//            commits the access and presents the response until it is taken.
//            Stores are byte-lane masked; loads return lane data at bit 0.
// Params   : DEPTH_WORDS - number of 32-bit words
//            LATENCY     - wait cycles between accept and response (0 legal)
// Macros   : MISALIGN_TRAP_EN - when defined, misaligned half/word accesses
//            are rejected with rsp_err instead of being lane-truncated.
// Ports    : clk, reset (sync, active high)
//            req_valid/req_ready/req_we/req_addr/req_wdata/req_width
//            rsp_valid/rsp_ready/rsp_rdata/rsp_err
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_width,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    mem_rsp_state_e   state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             we_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    mem_width_e       width_q;
    logic             rsp_valid_q;
    logic [31:0]      rsp_rdata_q;
    logic             rsp_err_q;

    logic [31:0]      mem_q [DEPTH_WORDS];

    // ------------------------------------------------------------------
    // Active request: with zero latency the commit happens on the accept
    // edge, so the request is taken straight from the ports in IDLE.
    // ------------------------------------------------------------------
    logic        sel_idle;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    mem_width_e  sel_width;

    assign sel_idle  = (state_q == IDLE);
    assign sel_we    = sel_idle ? req_we    : we_q;
    assign sel_addr  = sel_idle ? req_addr  : addr_q;
    assign sel_wdata = sel_idle ? req_wdata : wdata_q;
    assign sel_width = sel_idle ? mem_width_e'(req_width) : width_q;

    logic accept;
    logic commit;

    assign req_ready = sel_idle && !reset;
    assign accept    = req_valid && req_ready;
    assign commit    = (accept && (LATENCY == 0)) || ((state_q == WAIT) && (cnt_q == '0));

    // ------------------------------------------------------------------
    // Address decode and error detection
    // ------------------------------------------------------------------
    logic [29:0] word_idx;
    logic        oob;
    logic        misalign;
    logic        sel_err;

    assign word_idx = sel_addr[31:2];
    assign oob      = ({2'b00, word_idx} >= 32'(DEPTH_WORDS));

`ifdef MISALIGN_TRAP_EN
    assign misalign = ((sel_width == MW_HALF) && sel_addr[0]) ||
                      ((sel_width == MW_WORD) && (sel_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign sel_err = oob || (sel_width == MW_RSVD) || misalign;

    // ------------------------------------------------------------------
    // Lane steering
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]          mem_idx;
    logic [31:0]               rword;
    logic [BYTES_PER_WORD-1:0] lane_be;
    logic [31:0]               lane_wdata;
    logic [31:0]               lane_rdata;

    assign mem_idx = word_idx[IDX_W-1:0];
    // Out-of-range indices never reach the array.
    assign rword   = oob ? '0 : mem_q[mem_idx];

    mem_lane_ctrl u_lane (
        .addr_lo_i (sel_addr[1:0]),
        .width_i   (sel_width),
        .wdata_i   (sel_wdata),
        .rword_i   (rword),
        .be_o      (lane_be),
        .wdata_o   (lane_wdata),
        .rdata_o   (lane_rdata)
    );

    logic [31:0] rsp_rdata_d;
    logic        rsp_err_d;
    logic        mem_wr;

    assign rsp_rdata_d = (sel_we || sel_err) ? '0 : lane_rdata;
    assign rsp_err_d   = sel_err;
    assign mem_wr      = commit && sel_we && !sel_err;

    // ------------------------------------------------------------------
    // Storage: cleared while reset is high, written only on commit.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_wr) begin
            for (int b = 0; b < BYTES_PER_WORD; b++) begin
                if (lane_be[b]) begin
                    mem_q[mem_idx][8*b +: 8] <= lane_wdata[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered response outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            width_q     <= MW_BYTE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        we_q    <= req_we;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        width_q <= mem_width_e'(req_width);
                        if (LATENCY == 0) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= rsp_rdata_d;
                            rsp_err_q   <= rsp_err_d;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= rsp_rdata_d;
                        rsp_err_q   <= rsp_err_d;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_responder
// Purpose  : Self-checking bench for data_mem_responder. A byte-array model
//            tracks memory contents and response timing; a per-cycle
//            compare process checks the DUT handshake and response against
//            it, and directed transactions pin known literal results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 1024;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_width;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int errors = 0;
    int checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    data_mem_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_width (req_width),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", name, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: byte-addressed memory plus response timeline
    // ------------------------------------------------------------------
    logic [7:0]  model_mem [4*DEPTH];
    bit          m_started = 0;
    bit          m_busy = 0;
    bit          m_valid = 0;
    bit          m_after_reset = 0;
    logic        m_err = 1'b0;
    logic [31:0] m_rdata = '0;
    int          cyc = 0;
    int          due = 0;
    logic        p_we;
    logic [31:0] p_addr;
    logic [31:0] p_wdata;
    logic [1:0]  p_width;

    function automatic void model_apply(input logic we, input logic [31:0] a,
                                        input logic [31:0] wd, input logic [1:0] w,
                                        output logic err, output logic [31:0] rd);
        int n;
        logic [31:0] base;
        n   = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
        err = (w == 2'd3) || ((a >> 2) >= 32'(DEPTH));
`ifdef MISALIGN_TRAP_EN
        if (w == 2'd1 && a[0]) err = 1'b1;
        if (w == 2'd2 && a[1:0] != 2'b00) err = 1'b1;
`endif
        rd = '0;
        if (!err) begin
            base = a & ~32'(n - 1);
            for (int i = 0; i < n; i++) begin
                if (we) model_mem[base + 32'(i)] = wd[8*i +: 8];
                else    rd[8*i +: 8] = model_mem[base + 32'(i)];
            end
        end
        if (we) rd = '0;
    endfunction

    // Timeline: a request accepted at cycle c commits at cycle c+LAT and
    // is then presented until rsp_ready is seen.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                m_started     = 1;
                m_busy        = 0;
                m_valid       = 0;
                m_rdata       = '0;
                m_err         = 1'b0;
                m_after_reset = 1;
                for (int i = 0; i < 4*DEPTH; i++) model_mem[i] = 8'h00;
            end else begin
                m_after_reset = 0;
                if (m_valid) begin
                    if (rsp_ready) begin
                        m_valid = 0;
                        m_busy  = 0;
                    end
                end else if (!m_busy && req_valid) begin
                    m_busy  = 1;
                    p_we    = req_we;
                    p_addr  = req_addr;
                    p_wdata = req_wdata;
                    p_width = req_width;
                    due     = cyc + LAT;
                end
                if (m_busy && !m_valid && cyc == due) begin
                    model_apply(p_we, p_addr, p_wdata, p_width, m_err, m_rdata);
                    m_valid = 1;
                end
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (m_started) begin
            check("req_ready", 32'(req_ready), 32'(!m_busy && !reset));
            check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
            if (m_valid || m_after_reset) begin
                check("rsp_rdata", rsp_rdata, m_rdata);
                check("rsp_err", 32'(rsp_err), 32'(m_err));
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic wait_accept();
        bit ok;
        ok = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1;
                break;
            end
        end
        check("accept_timeout", 32'(ok), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [1:0] w, input int hold, input bit offer,
                          output logic [31:0] rd, output logic er);
        int k;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_width = w;
        wait_accept();
        for (k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        check("rsp_latency", 32'(k), 32'(LAT + 1));
        rd = rsp_rdata;
        er = rsp_err;
        if (offer) begin
            req_valid = 1'b1;
            req_we    = 1'b1;
            req_addr  = 32'h0;
            req_wdata = 32'hFFFF_FFFF;
            req_width = 2'b10;
        end
        for (int h = 0; h < hold; h++) @(negedge clk);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] ra;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; req_width = 2'b00; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Load from fresh memory.
        do_req(1'b0, 32'h10, 32'h0, 2'b10, 0, 0, rd, er);
        check("load10_rdata", rd, 32'h0);
        check("load10_err", 32'(er), 32'd0);

        // Word store, byte store, word readback.
        do_req(1'b1, 32'h20, 32'hDEADBEEF, 2'b10, 0, 0, rd, er);
        check("store_rdata_zero", rd, 32'h0);
        do_req(1'b1, 32'h22, 32'h00000055, 2'b00, 1, 0, rd, er);
        do_req(1'b0, 32'h20, 32'h0, 2'b10, 0, 0, rd, er);
        check("load20_word", rd, 32'hDE55BEEF);
        do_req(1'b0, 32'h22, 32'h0, 2'b01, 0, 0, rd, er);
        check("load22_half", rd, 32'h0000DE55);
        do_req(1'b0, 32'h23, 32'h0, 2'b00, 0, 0, rd, er);
        check("load23_byte", rd, 32'h000000DE);

        // Error cases leave memory untouched.
        do_req(1'b0, 32'(4*DEPTH), 32'h0, 2'b10, 0, 0, rd, er);
        check("oob_err", 32'(er), 32'd1);
        check("oob_rdata", rd, 32'h0);
        do_req(1'b1, 32'h20, 32'hFFFFFFFF, 2'b11, 0, 0, rd, er);
        check("rsvd_err", 32'(er), 32'd1);
        do_req(1'b0, 32'h20, 32'h0, 2'b10, 0, 0, rd, er);
        check("rsvd_readback", rd, 32'hDE55BEEF);

        // Response held for 5 cycles with a competing request offered.
        do_req(1'b0, 32'h20, 32'h0, 2'b10, 5, 1, rd, er);
        check("hold_rdata", rd, 32'hDE55BEEF);
        do_req(1'b0, 32'h0, 32'h0, 2'b10, 0, 0, rd, er);
        check("offered_not_taken", rd, 32'h0);

        // Misaligned word store.
        do_req(1'b1, 32'h21, 32'hCAFEF00D, 2'b10, 0, 0, rd, er);
        do_req(1'b0, 32'h20, 32'h0, 2'b10, 0, 0, ra, er);
`ifdef MISALIGN_TRAP_EN
        check("misalign_readback", ra, 32'hDE55BEEF);
`else
        check("misalign_readback", ra, 32'hCAFEF00D);
`endif

        // Reset during the wait of a store abandons it.
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h8;
        req_wdata = 32'h12345678; req_width = 2'b10;
        wait_accept();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        do_req(1'b0, 32'h8, 32'h0, 2'b10, 0, 0, rd, er);
        check("reset_abandon", rd, 32'h0);

        // Randomized traffic checked by the model.
        for (int t = 0; t < 300; t++) begin
            logic        we;
            logic [31:0] a;
            logic [1:0]  w;
            we = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 15))
                0:       a = 32'(4*DEPTH) + 32'($urandom_range(0, 64));
                1:       a = $urandom();
                default: a = 32'($urandom_range(0, 63));
            endcase
            w = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            do_req(we, a, $urandom(), w, $urandom_range(0, 3), 1'($urandom_range(0, 1)), rd, er);
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
